mult_fu: RTL and testbench

Pipelined RV32M multiply functional unit. It wraps the existing `MULT_STAGES`-deep `mult_stage` chain with an issue front end and a completion back end. The front end handles the issue handshake, extends operands per `funct`, and tracks tags. The back end selects the result half, buffers it in a completion FIFO, and drives the CDB handshake. It sits between the multiply reservation station and the CDB arbiter.

---
 rtl/mult_pkg.sv | 47 ++++
 rtl/mult_chain.sv | 52 +++++
 rtl/mult_stage.sv | 43 ++++
 rtl/mult_fu.sv | 216 +++++++++++++++++++++
 tb/tb_mult_fu.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the RV32M multiply unit.
//   MULT_STAGES  - depth of the mult_stage pipeline (latency of the chain)
//   PROD_W       - width of the internal product (two XLEN words)
//   mult_funct_e - funct3[1:0] encoding of MUL/MULH/MULHSU/MULHU
//   mult_tag_s   - side-band entry travelling alongside the chain
//   mult_cpl_s   - completion FIFO entry presented on the CDB
package mult_pkg;

    localparam int unsigned MULT_STAGES = 8;
    localparam int unsigned MULT_XLEN   = 32;
    localparam int unsigned MULT_TAG_W  = 6;
    localparam int unsigned PROD_W      = 2 * MULT_XLEN;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mult_funct_e;

    typedef struct packed {
        logic                  valid;
        logic [MULT_TAG_W-1:0] tag;
        mult_funct_e           funct;
    } mult_tag_s;

    typedef struct packed {
        logic [MULT_TAG_W-1:0] tag;
        logic [MULT_XLEN-1:0]  value;
    } mult_cpl_s;

    // Widen an operand to the product width; with both operands widened
    // this way the low PROD_W bits of a plain unsigned multiply are exact.
    function automatic logic [PROD_W-1:0] ext_operand(input logic [MULT_XLEN-1:0] op,
                                                      input logic                 is_signed);
        return {{(PROD_W - MULT_XLEN){is_signed & op[MULT_XLEN-1]}}, op};
    endfunction

    function automatic logic rs1_signed(input mult_funct_e f);
        return f != MULHU;
    endfunction

    function automatic logic rs2_signed(input mult_funct_e f);
        return (f == MUL) || (f == MULH);
    endfunction

endpackage

// File: rtl/mult_chain.sv
// mult_chain: MULT_STAGES mult_stage instances in series. Stage 0 starts
// from a zero running sum.
//   clock, reset  - clock and active-high synchronous reset
//   start         - launch a multiply this cycle
//   mcand, mplier - PROD_W-wide operands (already extended)
//   product       - low PROD_W bits of mcand*mplier, valid when done=1
//   done          - final stage done
module mult_chain
    import mult_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [PROD_W-1:0] mcand,
    input  logic [PROD_W-1:0] mplier,
    output logic [PROD_W-1:0] product,
    output logic              done
);

    logic [MULT_STAGES:0][PROD_W-1:0] sum_w;
    logic [MULT_STAGES:0][PROD_W-1:0] mcand_w;
    logic [MULT_STAGES:0][PROD_W-1:0] mplier_w;
    logic [MULT_STAGES:0]             done_w;

    assign sum_w[0]    = '0;
    assign mcand_w[0]  = mcand;
    assign mplier_w[0] = mplier;
    assign done_w[0]   = start;

    for (genvar i = 0; i < MULT_STAGES; i++) begin : g_stage
        mult_stage u_stage (
            .clock       (clock),
            .reset       (reset),
            .start       (done_w[i]),
            .prev_sum    (sum_w[i]),
            .mcand       (mcand_w[i]),
            .mplier      (mplier_w[i]),
            .product_sum (sum_w[i+1]),
            .next_mcand  (mcand_w[i+1]),
            .next_mplier (mplier_w[i+1]),
            .done        (done_w[i+1])
        );
    end

    assign product = sum_w[MULT_STAGES];
    assign done    = done_w[MULT_STAGES];

    // Operands shifted out of the last stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^{mcand_w[MULT_STAGES], mplier_w[MULT_STAGES]};

endmodule

// File: rtl/mult_stage.sv
// mult_stage: one slice of the pipelined multiplier. Each stage consumes
// PROD_W/MULT_STAGES multiplier bits, adds the partial product to the
// running sum, and passes shifted operands to the next stage.
//   clock, reset           - clock and active-high synchronous reset (done only)
//   start                  - operands valid at this stage's input
//   prev_sum, mcand, mplier- running sum and operands from the previous stage
//   product_sum            - registered running sum
//   next_mcand/next_mplier - registered shifted operands for the next stage
//   done                   - registered start
module mult_stage
    import mult_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [PROD_W-1:0] prev_sum,
    input  logic [PROD_W-1:0] mcand,
    input  logic [PROD_W-1:0] mplier,
    output logic [PROD_W-1:0] product_sum,
    output logic [PROD_W-1:0] next_mcand,
    output logic [PROD_W-1:0] next_mplier,
    output logic              done
);

    localparam int unsigned BITS = PROD_W / MULT_STAGES;

    logic [PROD_W-1:0] partial;

    assign partial = {{(PROD_W - BITS){1'b0}}, mplier[BITS-1:0]} * mcand;

    // Datapath registers carry don't-care values when idle; only done is reset.
    always_ff @(posedge clock) begin
        product_sum <= prev_sum + partial;
        next_mcand  <= {mcand[PROD_W-BITS-1:0], {BITS{1'b0}}};
        next_mplier <= {{BITS{1'b0}}, mplier[PROD_W-1:BITS]};
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= start;
        end
    end

endmodule

// File: rtl/mult_fu.sv
// mult_fu: pipelined RV32M multiply functional unit between the multiply
// reservation station and the CDB arbiter.
//   clock, reset_n           - clock, synchronous active-low reset
//   issue_valid/issue_ready  - issue handshake
//   issue_funct              - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
//   issue_rs1/rs2, issue_tag - operands and destination tag
//   flush                    - discard all in-flight and buffered work
//   cdb_valid/cdb_ready      - completion handshake (FIFO head)
//   cdb_tag, cdb_value       - FIFO head contents, zero when empty
// Issue-to-cdb_valid latency is MULT_STAGES+1; results leave in issue order.
module mult_fu
    import mult_pkg::*;
#(
    parameter int unsigned XLEN       = MULT_XLEN,
    parameter int unsigned TAG_W      = MULT_TAG_W,
    parameter int unsigned FIFO_DEPTH = MULT_STAGES + 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [1:0]       issue_funct,
    input  logic [XLEN-1:0]  issue_rs1,
    input  logic [XLEN-1:0]  issue_rs2,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             flush,
    output logic             cdb_valid,
    input  logic             cdb_ready,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_value
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CREDITS  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FIFO_DEPTH - 1);

    mult_funct_e issue_funct_e;
    logic        issue_fire;
    logic        cdb_fire;

    assign issue_funct_e = mult_funct_e'(issue_funct);
    assign issue_fire    = issue_valid & issue_ready;
    assign cdb_fire      = cdb_valid & cdb_ready;

    // ------------------------------------------------------------------
    // Credits: one per request between issue and CDB acceptance. Capping
    // at FIFO_DEPTH guarantees every completion finds a free FIFO slot,
    // so the chain never needs to stall.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign issue_ready = reset_n & ~flush & (cnt_q < CREDITS);

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (issue_fire && !cdb_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!issue_fire && cdb_fire) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Multiplier chain. Operands are don't-care when start is low, so the
    // extension logic drives them unconditionally.
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] chain_mcand;
    logic [PROD_W-1:0] chain_mplier;
    logic [PROD_W-1:0] chain_product;
    logic              chain_done;

    assign chain_mcand  = ext_operand(issue_rs1, rs1_signed(issue_funct_e));
    assign chain_mplier = ext_operand(issue_rs2, rs2_signed(issue_funct_e));

    mult_chain u_chain (
        .clock   (clock),
        .reset   (!reset_n),
        .start   (issue_fire),
        .mcand   (chain_mcand),
        .mplier  (chain_mplier),
        .product (chain_product),
        .done    (chain_done)
    );

    // ------------------------------------------------------------------
    // Side-band shift register: the last entry lines up with chain_done.
    // Flush drops only the valids; the chain keeps draining its done bits,
    // which are then ignored because no valid entry accompanies them.
    // ------------------------------------------------------------------
    mult_tag_s [MULT_STAGES-1:0] sb_q, sb_d;

    always_comb begin
        sb_d          = sb_q;
        sb_d[0].valid = issue_fire;
        sb_d[0].tag   = issue_tag;
        sb_d[0].funct = issue_funct_e;
        for (int unsigned i = 1; i < MULT_STAGES; i++) begin
            sb_d[i] = sb_q[i-1];
        end
        if (flush) begin
            for (int unsigned i = 0; i < MULT_STAGES; i++) begin
                sb_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MULT_STAGES; i++) begin
                sb_q[i].valid <= 1'b0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    // ------------------------------------------------------------------
    // Completion: pick the result half and enqueue.
    // ------------------------------------------------------------------
    mult_tag_s sb_last;
    mult_cpl_s cpl_in;
    logic      enq;

    assign sb_last = sb_q[MULT_STAGES-1];
    assign enq     = chain_done & sb_last.valid;

    always_comb begin
        cpl_in.tag   = sb_last.tag;
        cpl_in.value = (sb_last.funct == MUL) ? chain_product[MULT_XLEN-1:0]
                                              : chain_product[PROD_W-1:MULT_XLEN];
    end

    // ------------------------------------------------------------------
    // Completion FIFO: circular pointers with explicit full/empty flags.
    // ------------------------------------------------------------------
    mult_cpl_s        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        empty_d  = empty_q;
        if (enq) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (cdb_fire) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (enq && !cdb_fire) begin
            empty_d = 1'b0;
            full_d  = (ptr_inc(wr_ptr_q) == rd_ptr_q);
        end else if (!enq && cdb_fire) begin
            full_d  = 1'b0;
            empty_d = (ptr_inc(rd_ptr_q) == wr_ptr_q);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            full_d   = 1'b0;
            empty_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_q[wr_ptr_q] <= cpl_in;
        end
    end

    // ------------------------------------------------------------------
    // CDB outputs: gated by reset_n so nothing stale shows during reset.
    // ------------------------------------------------------------------
    mult_cpl_s head;

    assign head      = fifo_q[rd_ptr_q];
    assign cdb_valid = reset_n & ~empty_q;
    assign cdb_tag   = cdb_valid ? head.tag   : '0;
    assign cdb_value = cdb_valid ? head.value : '0;

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
                                    !(enq && full_q));

endmodule

// File: tb/tb_mult_fu.sv
module tb_mult_fu;

    localparam int DEPTH = 10;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [1:0]  issue_funct = '0;
    logic [31:0] issue_rs1 = '0;
    logic [31:0] issue_rs2 = '0;
    logic [5:0]  issue_tag = '0;
    logic        flush = 1'b0;
    logic        cdb_valid;
    logic        cdb_ready = 1'b0;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;

    always #5 clock = ~clock;

    mult_fu #(.XLEN(32), .TAG_W(6), .FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_funct (issue_funct),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_tag   (issue_tag),
        .flush       (flush),
        .cdb_valid   (cdb_valid),
        .cdb_ready   (cdb_ready),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: exact 64-bit arithmetic on signed/unsigned interpretations.
    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f)
            2'd0:    begin p = sa * sb;           return p[31:0];  end
            2'd1:    begin p = sa * sb;           return p[63:32]; end
            2'd2:    begin p = sa * longint'(ub); return p[63:32]; end
            default: begin p = ua * ub;           return p[63:32]; end
        endcase
    endfunction

    typedef struct { logic [5:0] tag; logic [31:0] value; } cpl_t;
    cpl_t exp_q[$];

    // Scoreboard: outstanding work, expected ready, in-order completions.
    always @(negedge clock) begin
        logic exp_ready;
        cpl_t e;
        cpl_t n;
        exp_ready = reset_n && !flush && (exp_q.size() < DEPTH);
        chk("issue_ready", issue_ready, exp_ready);
        if (!cdb_valid) begin
            chk("idle_tag", cdb_tag, 0);
            chk("idle_value", cdb_value, 0);
        end
        if (exp_q.size() == 0 || !reset_n) chk("no_spurious_cdb", cdb_valid, 0);
        if (cdb_valid && cdb_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_tag", cdb_tag, e.tag);
            chk("sb_value", cdb_value, e.value);
        end
        if (!reset_n || flush) begin
            exp_q.delete();
        end else if (issue_valid && issue_ready) begin
            n.tag   = issue_tag;
            n.value = ref_mul(issue_funct, issue_rs1, issue_rs2);
            exp_q.push_back(n);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_issue(input logic v, input logic [1:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [5:0] t);
        issue_valid = v;
        issue_funct = f;
        issue_rs1   = a;
        issue_rs2   = b;
        issue_tag   = t;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_rand(input logic v);
        drive_issue(v, 2'($urandom_range(0, 3)), rand_op(), rand_op(), 6'($urandom));
    endtask

    typedef struct {
        logic [1:0]  funct;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  tag;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int          lat, acc, got;
        logic [5:0]  got_tag;
        logic [31:0] got_val;

        vecs[0] = '{2'd0, 32'd7,         32'hFFFF_FFFD, 6'd5,  32'hFFFF_FFEB};
        vecs[1] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 6'd11, 32'h4000_0000};
        vecs[2] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd63, 32'hFFFF_FFFE};
        vecs[3] = '{2'd2, 32'hFFFF_FFFF, 32'd2,         6'd0,  32'hFFFF_FFFF};
        vecs[4] = '{2'd0, 32'd3,         32'd4,         6'd33, 32'd12};
        vecs[5] = '{2'd1, 32'hFFFF_FFFF, 32'd1,         6'd7,  32'hFFFF_FFFF};
        vecs[6] = '{2'd3, 32'h8000_0000, 32'd2,         6'd20, 32'd1};
        vecs[7] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'd42, 32'h8000_0000};

        // Reset, then first cycle after release.
        cdb_ready = 1'b1;
        repeat (3) begin
            step();
            @(negedge clock);
            chk("rst_issue_ready", issue_ready, 0);
            chk("rst_cdb_valid", cdb_valid, 0);
        end
        step();
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset_ready", issue_ready, 1);

        // Single-issue vectors: value, tag and latency.
        foreach (vecs[i]) begin
            step();
            drive_issue(1'b1, vecs[i].funct, vecs[i].rs1, vecs[i].rs2, vecs[i].tag);
            @(negedge clock);
            chk($sformatf("vec%0d_fire", i), issue_ready, 1);
            lat = 0;
            got_tag = '0;
            got_val = '0;
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                step();
                if (c == 1) issue_valid = 1'b0;
                @(negedge clock);
                if (cdb_valid) begin
                    lat = c;
                    got_tag = cdb_tag;
                    got_val = cdb_value;
                end
            end
            chk($sformatf("vec%0d_latency", i), lat, 9);
            chk($sformatf("vec%0d_value", i), got_val, vecs[i].exp);
            chk($sformatf("vec%0d_tag", i), got_tag, vecs[i].tag);
        end

        // 20 back-to-back issues with cdb_ready=1.
        for (int k = 0; k < 34; k++) begin
            step();
            if (k < 20) drive_rand(1'b1);
            else issue_valid = 1'b0;
            @(negedge clock);
            if (k < 20) chk("b2b_ready", issue_ready, 1);
            chk("b2b_cdb_valid", cdb_valid, (k >= 9 && k <= 28));
        end

        // Credit limit with CDB stalled, then drain.
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            cdb_ready = 1'b0;
            drive_rand(1'b1);
            @(negedge clock);
            if (issue_ready) acc++;
        end
        chk("credit_accepted", acc, 10);
        chk("credit_blocked", issue_ready, 0);
        got = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            issue_valid = 1'b0;
            cdb_ready = 1'b1;
            @(negedge clock);
            if (cdb_valid) got++;
        end
        chk("credit_drained", got, 10);

        // Flush with 5 in the chain and 2 in the FIFO.
        for (int k = 0; k < 12; k++) begin
            step();
            cdb_ready = (k == 11);
            flush = (k == 10);
            if (k < 7 || k == 10) drive_rand(1'b1);
            else if (k == 11) drive_issue(1'b1, 2'd0, 32'd3, 32'd4, 6'h2A);
            else issue_valid = 1'b0;
            @(negedge clock);
            if (k == 9) chk("flush_pre_fifo_valid", cdb_valid, 1);
            if (k == 10) chk("flush_blocks_issue", issue_ready, 0);
            if (k == 11) begin
                chk("flush_next_ready", issue_ready, 1);
                chk("flush_next_cdb_valid", cdb_valid, 0);
            end
        end
        lat = 0;
        got_tag = '0;
        got_val = '0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            step();
            if (c == 1) issue_valid = 1'b0;
            @(negedge clock);
            if (cdb_valid) begin
                lat = c;
                got_tag = cdb_tag;
                got_val = cdb_value;
            end
        end
        chk("post_flush_latency", lat, 9);
        chk("post_flush_value", got_val, 12);
        chk("post_flush_tag", got_tag, 6'h2A);

        // One-cycle reset pulse mid-stream.
        for (int k = 0; k < 21; k++) begin
            step();
            cdb_ready = 1'b1;
            reset_n = (k != 4);
            if (k < 5) drive_rand(1'b1);
            else issue_valid = 1'b0;
            @(negedge clock);
            if (k == 4) begin
                chk("midrst_ready", issue_ready, 0);
                chk("midrst_cdb_valid", cdb_valid, 0);
                chk("midrst_cdb_tag", cdb_tag, 0);
                chk("midrst_cdb_value", cdb_value, 0);
            end
            if (k == 5) chk("midrst_release_ready", issue_ready, 1);
            if (k >= 5) chk("midrst_no_stale", cdb_valid, 0);
        end

        // Random traffic against the scoreboard.
        for (int k = 0; k < 300; k++) begin
            step();
            drive_rand($urandom_range(0, 3) != 0);
            cdb_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 59) == 0);
            @(negedge clock);
        end
        step();
        issue_valid = 1'b0;
        flush = 1'b0;
        cdb_ready = 1'b1;
        @(negedge clock);
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
            step();
            @(negedge clock);
        end
        chk("final_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
